alu_ctrl_fsm: RTL and testbench
===============================

Name: alu_ctrl_fsm

Overview:
Multi-cycle control unit that drives the 6-bit function code of the existing 32-bit ALU and every datapath strobe for the multi-cycle CPU. It decodes opcode/funct and sequences FETCH→DECODE→EXECUTE→MEM→WRITEBACK with a memory-ready handshake. It sits between the instruction register and the shared datapath: one ALU, one memory port, one register file.

Parameters:
- RESET_STATE, 4'd0, state entered on reset (FETCH).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU result == 0, valid in BRANCH
- mem_ready  in  1  memory handshake; access completes on the cycle it is high
- alu_f  out  6  ALU function code
- alu_src_a  out  1  0=PC, 1=regA
- alu_src_b  out  2  0=regB, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
- pc_src  out  2  0=ALU result, 1=ALUOut reg, 2=jump target
- pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write  out  1 each  datapath strobes
- illegal  out  1  one-cycle pulse on an unsupported instruction
- state  out  4  current state, for debug and coverage

Behaviour:
- alu_f encoding. F[2:0] selects the result: 0 AND, 1 OR, 2 ADD/SUB, 3 SLT, 4 NOT A, 5 XOR, 6 MUL (16x16), 7 SHIFT. F[3]=1 inverts B and sets carry-in (SUB and SLT). F[5:4] selects the shift: 00 SLL, 01 SRL, 10 SRA.
- Codes: ADD=6'h02, SUB=6'h0A, AND=6'h00, OR=6'h01, SLT=6'h0B, XOR=6'h05, MUL=6'h06, SLL=6'h07, SRL=6'h17, SRA=6'h27.
- Output model. All outputs are decoded from the state register. Strobes not listed for a state are 0, and alu_f defaults to ADD.
- States (encoding):
  - FETCH(0): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_f=ADD, pc_src=0. ir_write=pc_write=mem_ready. Stay in FETCH until mem_ready, then go to DECODE.
  - DECODE(1): alu_src_a=0, alu_src_b=3, alu_f=ADD (precompute branch target). Next state by opcode:
    - 0x23 or 0x2B → MEMADR
    - 0x00 → EXEC, when funct ∈ {0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x26 xor, 0x2A slt, 0x18 mul, 0x00 sll, 0x02 srl, 0x03 sra}
    - 0x04 → BRANCH
    - 0x08, 0x0C, 0x0D → IEXEC
    - 0x02 → JUMP
    - anything else (including an unlisted funct with opcode 0x00) → FETCH with illegal=1 for that cycle.
  - MEMADR(2): alu_src_a=1, alu_src_b=2, alu_f=ADD. Go to MEMRD for lw, MEMWR for sw.
  - MEMRD(3): mem_read=1, i_or_d=1. Hold until mem_ready, then go to MEMWB.
  - MEMWB(4): reg_write=1, mem_to_reg=1, reg_dst=0. Go to FETCH.
  - MEMWR(5): mem_write=1, i_or_d=1. Hold until mem_ready, then go to FETCH.
  - EXEC(6): alu_src_a=1, alu_src_b=0, alu_f from the funct map. Go to ALUWB.
  - ALUWB(7): reg_write=1, reg_dst=1, mem_to_reg=0. Go to FETCH.
  - BRANCH(8): alu_src_a=1, alu_src_b=0, alu_f=SUB, pc_write_cond=1, pc_src=1. Go to FETCH.
  - IEXEC(9): alu_src_a=1, alu_src_b=2, alu_f = ADD/AND/OR for 0x08/0x0C/0x0D. Go to IWB(11).
  - IWB(11): reg_write=1, reg_dst=0. Go to FETCH.
  - JUMP(10): pc_write=1, pc_src=2. Go to FETCH.
- Encodings 12–15 are unreachable. If ever entered, go to FETCH with all strobes 0.
- The effective PC write enable is pc_write | (pc_write_cond & zero). It is formed in the datapath, not in this block.
- Latency in cycles, each with zero memory wait:
  - lw 5, sw 4
  - R-type 4, I-type 4
  - beq 3, j 3
  - Every mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- Reset:
  - While rst_n=0, regardless of clk: state=FETCH, illegal=0.
  - Outputs then show the FETCH decode with mem_ready gating: mem_read=1, alu_src_b=1, alu_f=6'h02, all other strobes 0 unless mem_ready=1.
  - Reset mid-instruction abandons that instruction. No partial write is held.
- The opcode and funct inputs must be stable from DECODE until the instruction returns to FETCH. The block does not latch them.

Test Plan:
- Reset, then lw (opcode 0x23) with mem_ready tied 1 → states 0,1,2,3,4,0. alu_f=02 in MEMADR. reg_write=1 and mem_to_reg=1 only in MEMWB. Total 5 cycles.
- R-type sub (funct 0x22), then sra (funct 0x03) → alu_f=0A, then 27, in EXEC. reg_dst=1 and reg_write=1 in ALUWB.
- beq with zero=1, then zero=0 → BRANCH shows alu_f=0A, pc_write_cond=1, pc_src=1. Effective PC write is 1, then 0.
- sw with mem_ready low for 3 cycles in MEMWR → state holds at 5 for 4 cycles. mem_write stays 1 throughout, and the FSM returns to FETCH after the mem_ready cycle.
- opcode 0x3F, then opcode 0 with funct 0x01 → illegal pulses for exactly 1 cycle in DECODE. Next state is FETCH and no write strobe is asserted.
- rst_n dropped asynchronously in MEMRD, mid-cycle → state=0 immediately, before the next clk edge. After release, normal fetch resumes.

Source files
------------

// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle CPU control unit: sequences fetch/decode/execute/mem/writeback
// and drives the ALU function code plus every datapath strobe.
module alu_ctrl_fsm #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [5:0] alu_f,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXEC  = 4'd9,
        S_JUMP   = 4'd10,
        S_IWB    = 4'd11
    } state_t;

    localparam logic [5:0] F_AND = 6'h00;
    localparam logic [5:0] F_OR  = 6'h01;
    localparam logic [5:0] F_ADD = 6'h02;
    localparam logic [5:0] F_XOR = 6'h05;
    localparam logic [5:0] F_MUL = 6'h06;
    localparam logic [5:0] F_SLL = 6'h07;
    localparam logic [5:0] F_SUB = 6'h0A;
    localparam logic [5:0] F_SLT = 6'h0B;
    localparam logic [5:0] F_SRL = 6'h17;
    localparam logic [5:0] F_SRA = 6'h27;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    state_t st_q;
    state_t st_d;

    logic       op_ld;
    logic       op_st;
    logic       op_r;
    logic       op_beq;
    logic       op_imm;
    logic       op_j;
    logic       r_ok;
    logic [5:0] r_f;
    logic [5:0] i_f;
    state_t     dec_nxt;
    logic       dec_bad;

    assign op_ld  = (opcode == OP_LW);
    assign op_st  = (opcode == OP_SW);
    assign op_r   = (opcode == OP_R);
    assign op_beq = (opcode == OP_BEQ);
    assign op_j   = (opcode == OP_J);
    assign op_imm = (opcode == OP_ADDI) |
                    (opcode == OP_ANDI) |
                    (opcode == OP_ORI);

    // R-type funct to ALU function code
    always_comb begin
        r_ok = 1'b1;
        r_f  = F_ADD;
        case (funct)
            6'h20:   r_f = F_ADD;
            6'h22:   r_f = F_SUB;
            6'h24:   r_f = F_AND;
            6'h25:   r_f = F_OR;
            6'h26:   r_f = F_XOR;
            6'h2A:   r_f = F_SLT;
            6'h18:   r_f = F_MUL;
            6'h00:   r_f = F_SLL;
            6'h02:   r_f = F_SRL;
            6'h03:   r_f = F_SRA;
            default: r_ok = 1'b0;
        endcase
    end

    always_comb begin
        i_f = F_ADD;
        case (opcode)
            OP_ANDI: i_f = F_AND;
            OP_ORI:  i_f = F_OR;
            default: i_f = F_ADD;
        endcase
    end

    always_comb begin
        dec_nxt = S_FETCH;
        dec_bad = 1'b0;
        unique case (1'b1)
            op_ld | op_st: dec_nxt = S_MEMADR;
            op_r & r_ok:   dec_nxt = S_EXEC;
            op_beq:        dec_nxt = S_BRANCH;
            op_imm:        dec_nxt = S_IEXEC;
            op_j:          dec_nxt = S_JUMP;
            default:       dec_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q <= state_t'(RESET_STATE);
        end else begin
            st_q <= st_d;
        end
    end

    // Outputs are a pure decode of the state register; only the
    // memory handshake and the decode result gate individual strobes.
    always_comb begin
        st_d          = st_q;
        alu_f         = F_ADD;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        pc_src        = 2'd0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        illegal       = 1'b0;
        case (st_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    st_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'd3;
                illegal   = dec_bad;
                st_d      = dec_nxt;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                st_d      = op_ld ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    st_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                st_d       = S_FETCH;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    st_d = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_f     = r_f;
                st_d      = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                st_d      = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_f         = F_SUB;
                pc_write_cond = 1'b1;
                pc_src        = 2'd1;
                st_d          = S_FETCH;
            end
            S_IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                alu_f     = i_f;
                st_d      = S_IWB;
            end
            S_IWB: begin
                reg_write = 1'b1;
                st_d      = S_FETCH;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'd2;
                st_d     = S_FETCH;
            end
            default: begin
                st_d = S_FETCH;
            end
        endcase
    end

    assign state = st_q;

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Scoreboard bench for alu_ctrl_fsm: per-cycle expected outputs come from
// an instruction-level phase model and are checked by a separate monitor.
module tb_alu_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic [5:0] alu_f;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       illegal;
    logic [3:0] state;

    always #5 clk = ~clk;

    alu_ctrl_fsm dut (
        .clk(clk),
        .rst_n(rst_n),
        .opcode(opcode),
        .funct(funct),
        .zero(zero),
        .mem_ready(mem_ready),
        .alu_f(alu_f),
        .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b),
        .pc_src(pc_src),
        .pc_write(pc_write),
        .pc_write_cond(pc_write_cond),
        .i_or_d(i_or_d),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .ir_write(ir_write),
        .mem_to_reg(mem_to_reg),
        .reg_dst(reg_dst),
        .reg_write(reg_write),
        .illegal(illegal),
        .state(state)
    );

    typedef struct packed {
        logic [3:0] st;
        logic [5:0] f;
        logic       sa;
        logic [1:0] sb;
        logic [1:0] ps;
        logic       pw;
        logic       pwc;
        logic       iod;
        logic       mr;
        logic       mw;
        logic       irw;
        logic       m2r;
        logic       rd;
        logic       rw;
        logic       ill;
        logic       eff;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;
    bit   mon_en = 1'b0;

    // Phase numbers are the documented state encodings.
    localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3;
    localparam int P_MEMWB = 4, P_MEMWR = 5, P_EXEC = 6, P_ALUWB = 7;
    localparam int P_BRANCH = 8, P_IEXEC = 9, P_JUMP = 10, P_IWB = 11;

    function automatic bit legal_r(logic [5:0] fn);
        return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26,
                          6'h2A, 6'h18, 6'h00, 6'h02, 6'h03};
    endfunction

    function automatic bit legal(logic [5:0] op, logic [5:0] fn);
        if (op == 6'h00) return legal_r(fn);
        return op inside {6'h23, 6'h2B, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h02};
    endfunction

    function automatic logic [5:0] r_code(logic [5:0] fn);
        case (fn)
            6'h20: return 6'h02;
            6'h22: return 6'h0A;
            6'h24: return 6'h00;
            6'h25: return 6'h01;
            6'h26: return 6'h05;
            6'h2A: return 6'h0B;
            6'h18: return 6'h06;
            6'h00: return 6'h07;
            6'h02: return 6'h17;
            default: return 6'h27;
        endcase
    endfunction

    function automatic exp_t model(int ph, logic [5:0] op, logic [5:0] fn,
                                   logic mr, logic z);
        exp_t e;
        e = '0;
        e.st = ph[3:0];
        e.f  = 6'h02;
        case (ph)
            P_FETCH: begin
                e.mr = 1'b1; e.sb = 2'd1;
                e.irw = mr; e.pw = mr; e.eff = mr;
            end
            P_DECODE: begin
                e.sb = 2'd3; e.ill = !legal(op, fn);
            end
            P_MEMADR: begin e.sa = 1'b1; e.sb = 2'd2; end
            P_MEMRD:  begin e.mr = 1'b1; e.iod = 1'b1; end
            P_MEMWB:  begin e.rw = 1'b1; e.m2r = 1'b1; end
            P_MEMWR:  begin e.mw = 1'b1; e.iod = 1'b1; end
            P_EXEC:   begin e.sa = 1'b1; e.f = r_code(fn); end
            P_ALUWB:  begin e.rw = 1'b1; e.rd = 1'b1; end
            P_BRANCH: begin
                e.sa = 1'b1; e.f = 6'h0A; e.pwc = 1'b1;
                e.ps = 2'd1; e.eff = z;
            end
            P_IEXEC: begin
                e.sa = 1'b1; e.sb = 2'd2;
                e.f = (op == 6'h0C) ? 6'h00 : (op == 6'h0D) ? 6'h01 : 6'h02;
            end
            P_IWB:  e.rw = 1'b1;
            P_JUMP: begin e.pw = 1'b1; e.ps = 2'd2; e.eff = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (mon_en) begin
            a.st = state; a.f = alu_f; a.sa = alu_src_a; a.sb = alu_src_b;
            a.ps = pc_src; a.pw = pc_write; a.pwc = pc_write_cond;
            a.iod = i_or_d; a.mr = mem_read; a.mw = mem_write;
            a.irw = ir_write; a.m2r = mem_to_reg; a.rd = reg_dst;
            a.rw = reg_write; a.ill = illegal;
            a.eff = pc_write | (pc_write_cond & zero);
            checks++;
            if (q.size() == 0) begin
                $display("FAIL underflow: got=%h required=<queued entry>", a);
            end else begin
                e = q.pop_front();
                if (a === e) passes++;
                else $display("FAIL cycle st=%0d: got=%h required=%h",
                              e.st, a, e);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got=%h required=%h", name, act, req);
    endtask

    function automatic logic rbit();
        return logic'($urandom_range(0, 1));
    endfunction

    task automatic do_cycle(input int ph, input logic mr, input logic z);
        mem_ready = mr;
        zero = z;
        q.push_back(model(ph, opcode, funct, mr, z));
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int wf, input int wm, input logic bz);
        opcode = op;
        funct = fn;
        repeat (wf) do_cycle(P_FETCH, 1'b0, rbit());
        do_cycle(P_FETCH, 1'b1, rbit());
        do_cycle(P_DECODE, rbit(), rbit());
        if (op == 6'h23) begin
            do_cycle(P_MEMADR, rbit(), rbit());
            repeat (wm) do_cycle(P_MEMRD, 1'b0, rbit());
            do_cycle(P_MEMRD, 1'b1, rbit());
            do_cycle(P_MEMWB, rbit(), rbit());
        end else if (op == 6'h2B) begin
            do_cycle(P_MEMADR, rbit(), rbit());
            repeat (wm) do_cycle(P_MEMWR, 1'b0, rbit());
            do_cycle(P_MEMWR, 1'b1, rbit());
        end else if (op == 6'h00 && legal_r(fn)) begin
            do_cycle(P_EXEC, rbit(), rbit());
            do_cycle(P_ALUWB, rbit(), rbit());
        end else if (op == 6'h04) begin
            do_cycle(P_BRANCH, rbit(), bz);
        end else if (op inside {6'h08, 6'h0C, 6'h0D}) begin
            do_cycle(P_IEXEC, rbit(), rbit());
            do_cycle(P_IWB, rbit(), rbit());
        end else if (op == 6'h02) begin
            do_cycle(P_JUMP, rbit(), rbit());
        end
    endtask

    logic [5:0] ops[11] = '{6'h23, 6'h2B, 6'h00, 6'h00, 6'h00, 6'h04,
                            6'h08, 6'h0C, 6'h0D, 6'h02, 6'h3F};
    logic [5:0] fns[11] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A,
                            6'h18, 6'h00, 6'h02, 6'h03, 6'h01};

    initial begin
        rst_n = 1'b0;
        opcode = 6'h00;
        funct = 6'h00;
        zero = 1'b0;
        mem_ready = 1'b0;
        #2;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_mem_read", 32'(mem_read), 32'd1);
        chk("rst_alu_f", 32'(alu_f), 32'h02);
        chk("rst_src_b", 32'(alu_src_b), 32'd1);
        chk("rst_ir_write", 32'(ir_write), 32'd0);
        mem_ready = 1'b1;
        #1;
        chk("rst_ir_write_rdy", 32'(ir_write), 32'd1);
        chk("rst_pc_write_rdy", 32'(pc_write), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_state", 32'(state), 32'd0);
        mem_ready = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        run_instr(6'h23, 6'h00, 0, 0, 1'b0);
        run_instr(6'h00, 6'h22, 0, 0, 1'b0);
        run_instr(6'h00, 6'h03, 1, 0, 1'b0);
        run_instr(6'h04, 6'h00, 0, 0, 1'b1);
        run_instr(6'h04, 6'h00, 0, 0, 1'b0);
        run_instr(6'h2B, 6'h00, 0, 3, 1'b0);
        run_instr(6'h3F, 6'h00, 0, 0, 1'b0);
        run_instr(6'h00, 6'h01, 0, 0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            logic [5:0] op;
            logic [5:0] fn;
            op = ops[$urandom_range(0, 10)];
            fn = fns[$urandom_range(0, 10)];
            if ($urandom_range(0, 9) == 0) op = 6'($urandom);
            if ($urandom_range(0, 9) == 0) fn = 6'($urandom);
            run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3),
                      rbit());
        end

        // Asynchronous reset while a load waits in MEMRD.
        opcode = 6'h23;
        funct = 6'h00;
        do_cycle(P_FETCH, 1'b1, 1'b0);
        do_cycle(P_DECODE, 1'b0, 1'b0);
        do_cycle(P_MEMADR, 1'b0, 1'b0);
        mon_en = 1'b0;
        mem_ready = 1'b0;
        chk("memrd_state", 32'(state), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_state", 32'(state), 32'd0);
        chk("async_illegal", 32'(illegal), 32'd0);
        chk("async_mem_read", 32'(mem_read), 32'd1);
        chk("async_i_or_d", 32'(i_or_d), 32'd0);
        chk("async_reg_write", 32'(reg_write), 32'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_state", 32'(state), 32'd0);
        mon_en = 1'b1;
        run_instr(6'h00, 6'h20, 0, 0, 1'b0);
        run_instr(6'h23, 6'h00, 1, 2, 1'b0);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
